pps_conditioner: RTL and testbench
==================================

PPS_CONDITIONER -- requirements
Module: pps_conditioner

Interface
REQ-001 Parameter CLK_HZ, default 62500000, nominal clk_62m5 cycles per second.
REQ-002 Parameter TOL, default 625, accepted period deviation in cycles (10 ppm).
REQ-003 Parameter LOCK_CNT, default 3, consecutive good periods needed to lock or relock.
REQ-004 Parameter PULSE_LEN, default 6250000, one_pps high time in cycles (100 ms).
REQ-005 Parameter HOLD_MAX, default 60, maximum flywheel pulses in holdover before giving up.
REQ-006 clk_62m5  in  1  sole clock for all logic.
REQ-007 rst  in  1  reset, synchronous to clk_62m5, active-high.
REQ-008 pps_in  in  1  raw external GPS PPS, asynchronous.
REQ-009 one_pps  out  1  conditioned PPS; drives the elapsed-time counter reset.
REQ-010 pps_state  out  2  0=SEARCH, 1=LOCKED, 2=HOLDOVER; 3 never driven.
REQ-011 last_period  out  26  most recent accepted external period in cycles.
REQ-012 err_cnt  out  16  saturating count of glitch and missing-edge events.

Function
REQ-013 pps_in passes through a 2-flop synchroniser, then a registered rising-edge detector (ext_edge).
REQ-014 ext_cnt, 26 bits: loads 1 on an accepted ext_edge, otherwise increments, saturates at 2^26-1; N cycles between edges measure as N.
REQ-015 Good period: ext_cnt in [CLK_HZ-TOL, CLK_HZ+TOL] inclusive at ext_edge.
REQ-016 SEARCH: every ext_edge is accepted and reloads ext_cnt; good period increments good_cnt, otherwise good_cnt clears; one_pps stays 0.
REQ-017 SEARCH: good_cnt reaching LOCK_CNT moves to LOCKED, emits a pulse on that edge, and clears good_cnt.
REQ-018 LOCKED, good edge: emit pulse, update last_period, reload ext_cnt.
REQ-019 LOCKED, early edge (ext_cnt < CLK_HZ-TOL): ignored (no pulse, ext_cnt not reloaded), err_cnt +1.
REQ-020 LOCKED, ext_cnt reaching CLK_HZ+TOL+1 with no edge: move to HOLDOVER, emit a pulse that cycle, fly_cnt=1, hold_n=1, good_cnt=0, err_cnt +1.
REQ-021 HOLDOVER flywheel: fly_cnt increments each cycle; at fly_cnt==last_period, emit a pulse, fly_cnt=1, hold_n +1.
REQ-022 HOLDOVER: ext_edges are qualified as in SEARCH; good_cnt reaching LOCK_CNT moves to LOCKED with a pulse on that edge, which cancels the flywheel.
REQ-023 HOLDOVER: flywheel pulse while hold_n==HOLD_MAX moves to SEARCH instead of pulsing; one_pps ends at its normal length.
REQ-024 Pulse: one_pps rises 3 cycles after the first clk_62m5 edge that samples pps_in high (LOCKED path), stays high PULSE_LEN cycles; a new trigger while high restarts the length.
REQ-025 Flywheel and missing-edge pulses have the same 1-cycle register delay from the trigger cycle.
REQ-026 Simultaneous ext_edge and flywheel trigger in HOLDOVER: one pulse only; relock takes priority if good_cnt completes.
REQ-027 err_cnt saturates at 16'hFFFF.
REQ-028 last_period changes only on LOCKED good edges and on the SEARCH/HOLDOVER->LOCKED edge.

Reset
REQ-029 On rst: state SEARCH; one_pps=0; last_period=CLK_HZ; err_cnt=0; ext_cnt=0; fly_cnt=0; good_cnt=0; hold_n=0; synchroniser flops=0.
REQ-030 rst asserted mid-pulse forces one_pps to 0 on the next clock edge; rst has priority over all events.

Verification (CLK_HZ=1000, TOL=2, LOCK_CNT=3, PULSE_LEN=10, HOLD_MAX=4)
REQ-031 pps_in edges every 1000 cycles -> pps_state=1 after the 4th edge; one_pps 10 cycles wide, rising 3 cycles after each sampled edge; last_period=1000.
REQ-032 Locked, extra 2-cycle glitch 400 cycles after an edge -> no pulse, err_cnt=1, next edge at 1000 pulses normally.
REQ-033 Locked, edges stop -> HOLDOVER pulse at ext_cnt=1003, then pulses every 1000 cycles; after 4 flywheel pulses, state=0, err_cnt=1.
REQ-034 HOLDOVER, edges resume at 999-cycle spacing -> flywheel pulses continue; LOCKED on the 3rd good period with last_period=999.
REQ-035 Edges at 1005 spacing -> remains SEARCH, one_pps never asserted.
REQ-036 rst pulse 5 cycles into a one_pps pulse -> one_pps=0 next cycle; all outputs at their reset values.

Source files
------------

// File: rtl/pps_conditioner.sv
// pps_conditioner
//   Cleans up a raw GPS PPS input and produces a conditioned one_pps pulse
//   that keeps running when the GPS reference drops out.
//   - pps_in is synchronised, edge-detected and its period is measured.
//   - After LOCK_CNT consecutive good periods the block locks and forwards
//     each good edge as a PULSE_LEN-cycle pulse. Edges that arrive early are
//     rejected as glitches.
//   - When an expected edge is missing, a flywheel keeps pulsing at the last
//     accepted period for up to HOLD_MAX pulses. It then falls back to SEARCH,
//     or it relocks if good edges come back first.
//
// Ports
//   clk_62m5     in   sole clock
//   rst          in   synchronous, active-high reset
//   pps_in       in   raw external PPS, asynchronous to clk_62m5
//   one_pps      out  conditioned PPS, PULSE_LEN cycles high
//   pps_state    out  0=SEARCH, 1=LOCKED, 2=HOLDOVER
//   last_period  out  most recent accepted external period, in cycles
//   err_cnt      out  saturating count of glitch and missing-edge events
//
// State | meaning
// ------+------------------------------------------------------------------
// SEARCH   | qualify every edge; count consecutive good periods; no output
// LOCKED   | forward good edges as pulses; reject early edges
// HOLDOVER | flywheel at last_period; relock on LOCK_CNT good periods

module pps_conditioner #(
  parameter int unsigned CLK_HZ    = 62500000,
  parameter int unsigned TOL       = 625,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned PULSE_LEN = 6250000,
  parameter int unsigned HOLD_MAX  = 60
) (
  input  logic        clk_62m5,
  input  logic        rst,
  input  logic        pps_in,
  output logic        one_pps,
  output logic [1:0]  pps_state,
  output logic [25:0] last_period,
  output logic [15:0] err_cnt
);

  localparam int unsigned CW = 26;
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] PER_NOM = CW'(CLK_HZ);
  localparam logic [CW-1:0] PER_LO  = CW'(CLK_HZ - TOL);
  localparam logic [CW-1:0] PER_HI  = CW'(CLK_HZ + TOL);
  localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_CNT);
  localparam logic [HW-1:0] HOLD_N  = HW'(HOLD_MAX);
  localparam logic [PW-1:0] PULSE_RELOAD = PW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            sync3_q, sync3_d;
  logic            ext_edge_q, ext_edge_d;
  logic [CW-1:0]   ext_cnt_q, ext_cnt_d;
  logic [CW-1:0]   fly_cnt_q, fly_cnt_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic [HW-1:0]   hold_n_q, hold_n_d;
  logic [CW-1:0]   last_period_q, last_period_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            one_pps_q, one_pps_d;
  logic [PW-1:0]   pulse_rem_q, pulse_rem_d;

  logic            period_good;
  logic            period_late;
  logic [GW-1:0]   good_next;
  logic            lock_done;
  logic            fly_hit;
  logic            trigger;
  logic            err_inc;

  always_comb begin
    sync1_d       = pps_in;
    sync2_d       = sync1_q;
    sync3_d       = sync2_q;
    ext_edge_d    = sync2_q & ~sync3_q;

    state_d       = state_q;
    ext_cnt_d     = (ext_cnt_q == CNT_MAX) ? ext_cnt_q : ext_cnt_q + CW'(1);
    fly_cnt_d     = fly_cnt_q;
    good_cnt_d    = good_cnt_q;
    hold_n_d      = hold_n_q;
    last_period_d = last_period_q;
    trigger       = 1'b0;
    err_inc       = 1'b0;

    // ext_cnt holds the number of cycles since the last accepted edge
    period_good = (ext_cnt_q >= PER_LO) && (ext_cnt_q <= PER_HI);
    period_late = (ext_cnt_q > PER_HI);
    good_next   = period_good ? good_cnt_q + GW'(1) : '0;
    lock_done   = period_good && (good_next >= LOCK_N);
    fly_hit     = (fly_cnt_q == last_period_q);

    case (state_q)
      ST_SEARCH: begin
        fly_cnt_d = '0;
        hold_n_d  = '0;
        if (ext_edge_q) begin
          ext_cnt_d = CW'(1);
          if (lock_done) begin
            state_d       = ST_LOCKED;
            trigger       = 1'b1;
            good_cnt_d    = '0;
            last_period_d = ext_cnt_q;
          end else begin
            good_cnt_d = good_next;
          end
        end
      end

      ST_LOCKED: begin
        if (ext_edge_q && period_good) begin
          trigger       = 1'b1;
          last_period_d = ext_cnt_q;
          ext_cnt_d     = CW'(1);
        end else if (period_late) begin
          // Expected edge never came: start the flywheel with a pulse now.
          // A coincident late edge still restarts the period measurement.
          state_d    = ST_HOLDOVER;
          trigger    = 1'b1;
          fly_cnt_d  = CW'(1);
          hold_n_d   = HW'(1);
          good_cnt_d = '0;
          err_inc    = 1'b1;
          if (ext_edge_q) begin
            ext_cnt_d = CW'(1);
          end
        end else if (ext_edge_q) begin
          // early edge is a glitch; the period keeps running
          err_inc = 1'b1;
        end
      end

      ST_HOLDOVER: begin
        fly_cnt_d = fly_cnt_q + CW'(1);
        if (ext_edge_q) begin
          ext_cnt_d  = CW'(1);
          good_cnt_d = good_next;
        end
        // relock wins over a coincident flywheel tick; either way one pulse
        if (ext_edge_q && lock_done) begin
          state_d       = ST_LOCKED;
          trigger       = 1'b1;
          good_cnt_d    = '0;
          last_period_d = ext_cnt_q;
          fly_cnt_d     = '0;
          hold_n_d      = '0;
        end else if (fly_hit) begin
          if (hold_n_q >= HOLD_N) begin
            state_d   = ST_SEARCH;
            fly_cnt_d = '0;
            hold_n_d  = '0;
          end else begin
            trigger   = 1'b1;
            fly_cnt_d = CW'(1);
            hold_n_d  = hold_n_q + HW'(1);
          end
        end
      end

      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    err_cnt_d = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

    // A retrigger while high restarts the full pulse length.
    if (trigger) begin
      one_pps_d   = 1'b1;
      pulse_rem_d = PULSE_RELOAD;
    end else if (pulse_rem_q != '0) begin
      one_pps_d   = 1'b1;
      pulse_rem_d = pulse_rem_q - PW'(1);
    end else begin
      one_pps_d   = 1'b0;
      pulse_rem_d = '0;
    end
  end

  always_ff @(posedge clk_62m5) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      ext_edge_q    <= 1'b0;
      ext_cnt_q     <= '0;
      fly_cnt_q     <= '0;
      good_cnt_q    <= '0;
      hold_n_q      <= '0;
      last_period_q <= PER_NOM;
      err_cnt_q     <= '0;
      one_pps_q     <= 1'b0;
      pulse_rem_q   <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      ext_edge_q    <= ext_edge_d;
      ext_cnt_q     <= ext_cnt_d;
      fly_cnt_q     <= fly_cnt_d;
      good_cnt_q    <= good_cnt_d;
      hold_n_q      <= hold_n_d;
      last_period_q <= last_period_d;
      err_cnt_q     <= err_cnt_d;
      one_pps_q     <= one_pps_d;
      pulse_rem_q   <= pulse_rem_d;
    end
  end

  assign one_pps     = one_pps_q;
  assign pps_state   = state_q;
  assign last_period = last_period_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_pps_conditioner.sv
module tb_pps_conditioner;

  localparam int CLK_HZ    = 1000;
  localparam int TOL       = 2;
  localparam int LOCK_CNT  = 3;
  localparam int PULSE_LEN = 10;
  localparam int HOLD_MAX  = 4;
  localparam int LO        = CLK_HZ - TOL;
  localparam int HI        = CLK_HZ + TOL;

  logic        clk_62m5 = 1'b0;
  logic        rst      = 1'b1;
  logic        pps_in   = 1'b0;
  logic        one_pps;
  logic [1:0]  pps_state;
  logic [25:0] last_period;
  logic [15:0] err_cnt;

  always #5 clk_62m5 = ~clk_62m5;

  pps_conditioner #(
    .CLK_HZ   (CLK_HZ),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT),
    .PULSE_LEN(PULSE_LEN),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk_62m5   (clk_62m5),
    .rst        (rst),
    .pps_in     (pps_in),
    .one_pps    (one_pps),
    .pps_state  (pps_state),
    .last_period(last_period),
    .err_cnt    (err_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      if (errors >= 40) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  endtask

  // Timestamp model: every event is a posedge number. A raw sample taken at
  // posedge n is acted on at posedge n+3; a pulse triggered at posedge t is
  // high after posedges t .. t+PULSE_LEN-1.
  int cyc = 0;
  bit m_valid = 0;
  bit hist[5];
  bit m_edge, m_ok, m_fly;
  int m_state, m_last_acc, m_good, m_hold, m_last_fly, m_last_period, m_err;
  int m_pulse_t = -1000000;
  int m_period;

  always @(posedge clk_62m5) begin
    cyc = cyc + 1;
    if (rst) begin
      for (int i = 0; i < 5; i++) hist[i] = 1'b0;
      m_state       = 0;
      m_last_acc    = cyc + 1;
      m_good        = 0;
      m_hold        = 0;
      m_last_fly    = 0;
      m_last_period = CLK_HZ;
      m_err         = 0;
      m_pulse_t     = -1000000;
      m_valid       = 1'b1;
    end else begin
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0]  = pps_in;
      m_edge   = hist[3] && !hist[4];
      m_period = cyc - m_last_acc;
      m_ok     = (m_period >= LO) && (m_period <= HI);
      case (m_state)
        0: begin
          if (m_edge) begin
            m_last_acc = cyc;
            m_good = m_ok ? m_good + 1 : 0;
            if (m_good == LOCK_CNT) begin
              m_state = 1; m_good = 0; m_last_period = m_period; m_pulse_t = cyc;
            end
          end
        end
        1: begin
          if (m_edge && m_ok) begin
            m_pulse_t = cyc; m_last_period = m_period; m_last_acc = cyc;
          end else if (m_period > HI) begin
            m_state = 2; m_pulse_t = cyc; m_last_fly = cyc; m_hold = 1; m_good = 0;
            if (m_err < 65535) m_err++;
            if (m_edge) m_last_acc = cyc;
          end else if (m_edge) begin
            if (m_err < 65535) m_err++;
          end
        end
        default: begin
          m_fly = ((cyc - m_last_fly) == m_last_period);
          if (m_edge) begin
            m_last_acc = cyc;
            m_good = m_ok ? m_good + 1 : 0;
          end
          if (m_edge && m_good == LOCK_CNT) begin
            m_state = 1; m_good = 0; m_last_period = m_period; m_pulse_t = cyc; m_hold = 0;
          end else if (m_fly) begin
            if (m_hold == HOLD_MAX) begin
              m_state = 0; m_hold = 0;
            end else begin
              m_pulse_t = cyc; m_last_fly = cyc; m_hold++;
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk_62m5) begin
    if (m_valid) begin
      check("cyc_one_pps", one_pps, (cyc >= m_pulse_t) && (cyc < m_pulse_t + PULSE_LEN));
      check("cyc_state", pps_state, m_state);
      check("cyc_last_period", last_period, m_last_period);
      check("cyc_err_cnt", err_cnt, m_err);
    end
  end

  int rises = 0;
  bit prev_one = 1'b0;
  always @(negedge clk_62m5) begin
    if ((one_pps === 1'b1) && !prev_one) rises++;
    prev_one = (one_pps === 1'b1);
  end

  task automatic edge_then(input int k);
    pps_in = 1'b1;
    repeat (3) @(negedge clk_62m5);
    pps_in = 1'b0;
    repeat (k - 3) @(negedge clk_62m5);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_62m5);
    rst = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    pps_in = 1'b0;
    repeat (3) @(negedge clk_62m5);
    check("rst_one_pps", one_pps, 0);
    check("rst_state", pps_state, 0);
    check("rst_last_period", last_period, 1000);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;

    // lock at the 4th edge with 1000-cycle spacing
    repeat (200) @(negedge clk_62m5);
    base = rises;
    repeat (3) edge_then(1000);
    check("search_state", pps_state, 0);
    check("search_no_pulse", rises - base, 0);
    pps_in = 1'b1;
    repeat (3) @(negedge clk_62m5);
    check("lock_rise_not_yet", one_pps, 0);
    pps_in = 1'b0;
    @(negedge clk_62m5);
    check("lock_rise", one_pps, 1);
    check("lock_state", pps_state, 1);
    check("lock_last_period", last_period, 1000);
    repeat (9) @(negedge clk_62m5);
    check("pulse_10th_cycle", one_pps, 1);
    @(negedge clk_62m5);
    check("pulse_end", one_pps, 0);
    repeat (1000 - 14) @(negedge clk_62m5);
    edge_then(1000);

    // glitch 400 cycles after an edge
    edge_then(400);
    base = rises;
    pps_in = 1'b1;
    repeat (2) @(negedge clk_62m5);
    pps_in = 1'b0;
    repeat (20) @(negedge clk_62m5);
    check("glitch_no_pulse", rises - base, 0);
    check("glitch_err_cnt", err_cnt, 1);
    check("glitch_state", pps_state, 1);
    repeat (1000 - 400 - 22) @(negedge clk_62m5);
    base = rises;
    edge_then(1000);
    check("post_glitch_pulse", rises - base, 1);

    // edges stop: holdover entry at ext_cnt = 1003, then flywheel to SEARCH
    base = rises;
    repeat (6) @(negedge clk_62m5);
    check("holdover_pre_one_pps", one_pps, 0);
    check("holdover_pre_state", pps_state, 1);
    @(negedge clk_62m5);
    check("holdover_entry_one_pps", one_pps, 1);
    check("holdover_entry_state", pps_state, 2);
    repeat (4200 - 7) @(negedge clk_62m5);
    check("holdover_pulses", rises - base, 4);
    check("holdover_exit_state", pps_state, 0);
    check("holdover_err_cnt", err_cnt, 2);
    check("holdover_last_period", last_period, 1000);

    // holdover, then edges return at 999 spacing
    do_reset();
    repeat (200) @(negedge clk_62m5);
    repeat (5) edge_then(1000);
    check("d_locked", pps_state, 1);
    repeat (100) @(negedge clk_62m5);
    check("d_holdover", pps_state, 2);
    base = rises;
    repeat (3) edge_then(999);
    check("d_before_relock", pps_state, 2);
    pps_in = 1'b1;
    repeat (3) @(negedge clk_62m5);
    pps_in = 1'b0;
    @(negedge clk_62m5);
    check("d_relock_state", pps_state, 1);
    check("d_relock_period", last_period, 999);
    check("d_relock_pulse", one_pps, 1);
    repeat (999 - 4) @(negedge clk_62m5);
    edge_then(999);
    check("d_pulses", rises - base, 5);
    check("d_final_state", pps_state, 1);
    check("d_final_period", last_period, 999);

    // 1005-cycle spacing never locks
    do_reset();
    repeat (200) @(negedge clk_62m5);
    base = rises;
    repeat (6) edge_then(1005);
    check("e_no_pulse", rises - base, 0);
    check("e_state", pps_state, 0);

    // reset in the middle of a pulse
    do_reset();
    repeat (200) @(negedge clk_62m5);
    repeat (3) edge_then(999);
    pps_in = 1'b1;
    repeat (3) @(negedge clk_62m5);
    pps_in = 1'b0;
    @(negedge clk_62m5);
    check("f_lock_period", last_period, 999);
    repeat (4) @(negedge clk_62m5);
    check("f_pulse_5th_cycle", one_pps, 1);
    rst = 1'b1;
    @(negedge clk_62m5);
    check("f_rst_one_pps", one_pps, 0);
    check("f_rst_state", pps_state, 0);
    check("f_rst_last_period", last_period, 1000);
    check("f_rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk_62m5);
    check("f_after_rst_one_pps", one_pps, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
